// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding.
// Kept in a package so other blocks that observe the meter's state agree on the encoding.
package period_meter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_SYNC = 1'b0;
    localparam state_t ST_MEAS = 1'b1;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// Two-flop synchronizer plus one delay flop, with rising/falling edge detect.
// Reusable for any slow asynchronous level that must be brought into the clk domain.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// flags whether the period is within tolerance, and times out when edges stop.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int EXP_PERIOD = 2,
    parameter int TOL        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             in_range,
    output logic             timeout,
    output logic             active
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Window bounds carry one extra bit so EXP_PERIOD+TOL cannot wrap; the low
    // bound is clamped at zero instead of underflowing when TOL > EXP_PERIOD.
    localparam int LO_I = (TOL > EXP_PERIOD) ? 0 : EXP_PERIOD - TOL;
    localparam int HI_I = EXP_PERIOD + TOL;
    localparam logic [CNT_W:0] LO_C = (CNT_W+1)'(LO_I);
    localparam logic [CNT_W:0] HI_C = (CNT_W+1)'(HI_I);

    logic             sig_s;
    logic             rise;
    logic             fall_unused;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W:0]   cnt_ext;

    sync_edge_det u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sig_in),
        .q     (sig_s),
        .rise  (rise),
        .fall  (fall_unused)
    );

    assign cnt_ext = {1'b0, cnt};
    assign active  = (state == ST_MEAS);

    // NOTE: only control and result registers are reset; there is no memory here that would need it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SYNC;
            cnt        <= '0;
            hcnt       <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            in_range   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            if (state == ST_SYNC) begin
                if (rise) begin
                    state <= ST_MEAS;
                    cnt   <= CNT_W'(1);
                    hcnt  <= CNT_W'(1);
                end else begin
                    cnt  <= '0;
                    hcnt <= '0;
                end
            end else begin
                // A rise on the timeout cycle still completes a normal measurement.
                if (rise) begin
                    period_out <= cnt;
                    high_out   <= hcnt;
                    in_range   <= (cnt_ext >= LO_C) && (cnt_ext <= HI_C);
                    valid      <= 1'b1;
                    cnt        <= CNT_W'(1);
                    hcnt       <= CNT_W'(1);
                end else if (cnt == TIMEOUT_C) begin
                    timeout <= 1'b1;
                    state   <= ST_SYNC;
                    cnt     <= '0;
                    hcnt    <= '0;
                end else begin
                    cnt  <= cnt + CNT_W'(1);
                    hcnt <= hcnt + CNT_W'(sig_s);
                end
            end
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed scoreboard bench for period_meter: one instance with EXP_PERIOD=8/TOL=1/TIMEOUT=20
// and one with default parameters for the divide-by-2 case.
module tb_period_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 20;
    localparam int EXP   = 8;
    localparam int TOLV  = 1;

    typedef struct {
        logic             is_to;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic             rng;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sig_in = 1'b0;
    logic             sig2 = 1'b0;
    logic [CNT_W-1:0] period_out, high_out, period2, high2;
    logic             valid, in_range, timeout, active;
    logic             valid2, in_range2, timeout2, active2;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t q2[$];
    exp_t mon_e, mon_e2;
    logic rst_q = 1'b1;
    logic [CNT_W-1:0] m_p = '0, m_h = '0, m2_p = '0, m2_h = '0;
    logic m_r = 1'b0, m2_r = 1'b0;
    bit   armed = 0;
    int   prev_p = 0, prev_h = 0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .EXP_PERIOD(EXP), .TOL(TOLV)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .period_out(period_out), .high_out(high_out),
        .valid(valid), .in_range(in_range), .timeout(timeout), .active(active)
    );

    period_meter dut2 (
        .clk(clk), .reset(reset), .sig_in(sig2), .period_out(period2), .high_out(high2),
        .valid(valid2), .in_range(in_range2), .timeout(timeout2), .active(active2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= reset;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rng_of(input int p);
        return (p >= EXP - TOLV) && (p <= EXP + TOLV);
    endfunction

    task automatic push_meas(input int p, input int h);
        exp_t e;
        e.is_to  = 1'b0;
        e.period = CNT_W'(p);
        e.high   = CNT_W'(h);
        e.rng    = rng_of(p);
        q.push_back(e);
    endtask

    task automatic push_timeout;
        exp_t e;
        e.is_to  = 1'b1;
        e.period = '0;
        e.high   = '0;
        e.rng    = 1'b0;
        q.push_back(e);
    endtask

    // One square-wave period: the rise closes the previous period if the meter is measuring.
    task automatic wave(input int h, input int l);
        if (armed) push_meas(prev_p, prev_h);
        armed  = 1;
        prev_p = h + l;
        prev_h = h;
        sig_in = 1'b1;
        repeat (h) tick();
        sig_in = 1'b0;
        repeat (l) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period_out, 0);
        chk({tag, "_high"}, high_out, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_in_range"}, in_range, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_active"}, active, 0);
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            m_p = '0; m_h = '0; m_r = 1'b0;
            chk("rst_valid", valid, 0);
            chk("rst_timeout", timeout, 0);
            chk("rst_active", active, 0);
        end else if (valid || timeout) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {30'b0, valid, timeout}, 0);
            end else begin
                mon_e = q.pop_front();
                chk("event_kind", {30'b0, valid, timeout}, mon_e.is_to ? 32'd1 : 32'd2);
                if (!mon_e.is_to) begin
                    m_p = mon_e.period; m_h = mon_e.high; m_r = mon_e.rng;
                end
            end
        end
        chk("period_out", period_out, m_p);
        chk("high_out", high_out, m_h);
        chk("in_range", in_range, m_r);
    end

    always @(negedge clk) begin
        if (rst_q) begin
            m2_p = '0; m2_h = '0; m2_r = 1'b0;
        end else if (valid2) begin
            if (q2.size() == 0) begin
                chk("d2_unexpected_valid", valid2, 0);
            end else begin
                mon_e2 = q2.pop_front();
                m2_p = mon_e2.period; m2_h = mon_e2.high; m2_r = mon_e2.rng;
            end
        end
        chk("d2_timeout", timeout2, 0);
        chk("d2_period", period2, m2_p);
        chk("d2_high", high2, m2_h);
        chk("d2_in_range", in_range2, m2_r);
    end

    initial begin
        exp_t e2;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        tick();

        // Divide-by-2 on the default-parameter instance.
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                e2.is_to = 1'b0; e2.period = 16'd2; e2.high = 16'd1; e2.rng = 1'b1;
                q2.push_back(e2);
            end
            sig2 = 1'b1;
            tick();
            sig2 = 1'b0;
            tick();
        end
        repeat (6) tick();
        chk("d2_queue_drained", q2.size(), 0);

        // In-window periods, a long out-of-window one, and a period equal to TIMEOUT.
        wave(3, 5);
        wave(3, 5);
        wave(3, 5);
        wave(4, 6);
        wave(3, 5);
        wave(10, 10);
        wave(2, 3);

        // Latency of one rise, then sig_in stuck low until the timeout.
        push_meas(prev_p, prev_h);
        sig_in = 1'b1;
        tick();
        tick();
        chk("latency_early_valid", valid, 0);
        sig_in = 1'b0;
        tick();
        chk("latency_valid", valid, 1);
        push_timeout();
        armed = 0;
        repeat (19) tick();
        chk("pre_timeout", timeout, 0);
        chk("pre_timeout_active", active, 1);
        tick();
        chk("timeout_pulse", timeout, 1);
        chk("timeout_active", active, 0);
        tick();
        chk("timeout_single", timeout, 0);
        repeat (20) tick();

        // Reset in the middle of a period.
        wave(3, 5);
        wave(3, 5);
        push_meas(prev_p, prev_h);
        sig_in = 1'b1;
        repeat (3) tick();
        sig_in = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk_zero("mid_reset");
        reset = 1'b0;
        armed = 0;
        tick();
        wave(3, 5);
        wave(3, 5);
        wave(3, 5);
        push_timeout();
        repeat (30) tick();

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1000: cycles without a rising edge before timeout; legal range 3 .. 2**CNT_W-1.
REQ-003 SHALL have parameter EXP_PERIOD, default 2: expected period in clk cycles.
REQ-004 SHALL have parameter TOL, default 0: allowed +/- deviation from EXP_PERIOD.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port sig_in, input, 1 bit: square wave to measure, asynchronous to clk, e.g. a divided clock.
REQ-008 SHALL have port period_out, output, CNT_W bits: last measured period in clk cycles.
REQ-009 SHALL have port high_out, output, CNT_W bits: clk cycles the synchronized sig_in was high in that period.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse when period_out and high_out are updated.
REQ-011 SHALL have port in_range, output, 1 bit: period_out is within EXP_PERIOD +/- TOL; updated with valid.
REQ-012 SHALL have port timeout, output, 1 bit: one-cycle pulse when no rising edge arrives within TIMEOUT cycles.
REQ-013 SHALL have port active, output, 1 bit: high while the FSM is in MEAS.

Function
REQ-014 SHALL pass sig_in through a 2-flop synchronizer (s1, s2) and a third delay flop (s3); rise = s2 & ~s3.
REQ-015 SHALL implement FSM states SYNC (waiting for the first rising edge) and MEAS (counting).
REQ-016 SYNC: on rise, SHALL go to MEAS and set cnt=1, hcnt=1; otherwise SHALL hold with counters at 0.
REQ-017 MEAS, cycle without rise: SHALL do cnt+=1 and hcnt+=s2.
REQ-018 MEAS, cycle with rise: SHALL load period_out=cnt and high_out=hcnt, pulse valid the next cycle, and set cnt=1, hcnt=1.
REQ-019 in_range SHALL be registered together with period_out as (EXP_PERIOD-TOL <= cnt <= EXP_PERIOD+TOL), compared at width CNT_W+1 with no underflow.
REQ-020 MEAS, cnt==TIMEOUT with no rise: SHALL pulse timeout the next cycle, go to SYNC, and clear the counters; valid SHALL NOT pulse.
REQ-021 Rise in the same cycle as cnt==TIMEOUT: the rise SHALL win, a normal measurement SHALL occur, and no timeout SHALL be raised.
REQ-022 Counters SHALL never exceed TIMEOUT, so no wrap-around is possible.
REQ-023 Latency: sig_in sampled high at clk edge k SHALL give valid high in the cycle after edge k+2.
REQ-024 period_out, high_out and in_range SHALL hold their values between valid pulses.
REQ-025 A constant sig_in SHALL produce no valid and, after the first edge, exactly one timeout per entry into MEAS.

Reset
REQ-026 While reset is high at a clk edge, the block SHALL set s1, s2, s3, cnt, hcnt to 0 and the FSM to SYNC.
REQ-027 While reset is high, the block SHALL set period_out=0, high_out=0, valid=0, in_range=0, timeout=0 and active=0.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count; the first valid after reset SHALL need two rising edges.

Structure
REQ-029 The state encoding (SYNC, MEAS) SHALL live in a shared package.
REQ-030 Synchronizer plus edge detect SHALL be a sub-module sync_edge_det (ports clk, reset, d, q, rise, fall), reusable elsewhere.
REQ-031 The block SHALL use no derived or gated clocks; sig_in SHALL be used only as data.

Verification
REQ-032 Divide-by-2 of clk (toggling every cycle) -> SHALL give valid every 2 cycles, period_out=2, high_out=1, in_range=1.
REQ-033 sig_in 3 cycles high / 5 low, EXP_PERIOD=8, TOL=1 -> SHALL give period_out=8, high_out=3, in_range=1; a later 10-cycle period SHALL give in_range=0.
REQ-034 One edge, then sig_in stuck low with TIMEOUT=20 -> SHALL give a single timeout pulse 21 cycles after the rise detect, active=0, and no valid.
REQ-035 Period exactly TIMEOUT=20 -> SHALL give valid with period_out=20 and no timeout (simultaneous-event rule).
REQ-036 Reset pulsed mid-period -> SHALL clear all outputs the next cycle, give no valid at the next single edge, and give a correct valid at the second edge.
